// File: rtl/spi_pkg.sv
// Shared SPI master types and constants: FSM state encoding, data and bit-index widths.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package spi_pkg;

  localparam int SPI_DATA_W    = 8;
  localparam int SPI_BIT_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // First bit index shifted out for the chosen bit order.
  function automatic logic [SPI_BIT_IDX_W-1:0] spi_first_idx(input int msb_first);
    return (msb_first != 0) ? 3'd7 : 3'd0;
  endfunction

  // Last bit index shifted out for the chosen bit order.
  function automatic logic [SPI_BIT_IDX_W-1:0] spi_last_idx(input int msb_first);
    return (msb_first != 0) ? 3'd0 : 3'd7;
  endfunction

endpackage

// File: rtl/Mux8x1.sv
// 8:1 single-bit selector: o_y = i_d[i_sel].
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module Mux8x1 (
  input  logic [7:0] i_d,
  input  logic [2:0] i_sel,
  output logic       o_y
);

  // Select one data bit by index.
  always_comb begin
    o_y = i_d[i_sel];
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// Half-period counter and SPI mode-0 clock toggler with rise/fall strobes.
// Latency: tick every CLK_DIV cycles while i_run; sclk toggles on tick while i_shift.
// Backpressure: none; counter and sclk clear whenever i_run / i_shift drop.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_shift,
  output logic o_tick,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;

  assign o_tick = i_run && (r_cnt == CNT_LAST);
  assign o_rise = o_tick && i_shift && !r_sclk;
  assign o_fall = o_tick && i_shift && r_sclk;
  assign o_sclk = r_sclk;

  // Half-period counter: runs from 0 while any non-idle phase is active, wraps at CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // sclk idles low and toggles once per half-period only during the shift phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk <= 1'b0;
    end else if (!i_shift) begin
      r_sclk <= 1'b0;
    end else if (o_tick) begin
      r_sclk <= !r_sclk;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 byte master: IDLE->SETUP->SHIFT->HOLD, optional miso capture (macro SPI_MASTER_RX_EN).
// Latency: fixed, done pulses 18*CLK_DIV+1 cycles after start acceptance.
// Backpressure: start only accepted in IDLE (incl. done cycle); starts while busy are dropped.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SPI_DATA_W-1:0]    tx_data,
  input  logic                     miso,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     cs_n,
  output logic [SPI_BIT_IDX_W-1:0] bit_sel,
  output logic                     busy,
  output logic                     done,
  output logic [SPI_DATA_W-1:0]    rx_data
);

  localparam logic [SPI_BIT_IDX_W-1:0] BIT_FIRST = spi_first_idx(MSB_FIRST);
  localparam logic [SPI_BIT_IDX_W-1:0] BIT_LAST  = spi_last_idx(MSB_FIRST);

  spi_state_t                r_state;
  spi_state_t                w_state_nxt;
  logic [SPI_DATA_W-1:0]     r_shadow;
  logic [SPI_BIT_IDX_W-1:0]  r_bit_sel;
  logic                      r_done;
  logic                      w_accept;
  logic                      w_finish;
  logic                      w_tick;
  logic                      w_rise;
  logic                      w_fall;

  assign w_accept = (r_state == IDLE) && start;
  assign w_finish = (r_state == HOLD) && w_tick;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_run   (r_state != IDLE),
    .i_shift (r_state == SHIFT),
    .o_tick  (w_tick),
    .o_sclk  (sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  Mux8x1 u_bit_mux (
    .i_d   (r_shadow),
    .i_sel (r_bit_sel),
    .o_y   (mosi)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: each non-idle phase ends on a half-period tick; shift ends on the last falling edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SETUP;
      SETUP:   if (w_tick) w_state_nxt = SHIFT;
      SHIFT:   if (w_fall && (r_bit_sel == BIT_LAST)) w_state_nxt = HOLD;
      HOLD:    if (w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the byte at acceptance and step the bit index on every falling edge except the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_bit_sel <= BIT_FIRST;
    end else if (w_accept) begin
      r_shadow  <= tx_data;
      r_bit_sel <= BIT_FIRST;
    end else if (w_fall && (r_bit_sel != BIT_LAST)) begin
      r_bit_sel <= (MSB_FIRST != 0) ? (r_bit_sel - 3'd1) : (r_bit_sel + 3'd1);
    end
  end

  // Completion pulse lands on the first IDLE cycle after HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [SPI_DATA_W-1:0] r_rx_sh;
  logic [SPI_DATA_W-1:0] r_rx_data;

  // Sample miso on sclk rising edges in transmit bit order; publish with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sh   <= '0;
      r_rx_data <= '0;
    end else begin
      if (w_rise) begin
        r_rx_sh <= (MSB_FIRST != 0) ? {r_rx_sh[SPI_DATA_W-2:0], miso}
                                    : {miso, r_rx_sh[SPI_DATA_W-1:1]};
      end
      if (w_finish) begin
        r_rx_data <= r_rx_sh;
      end
    end
  end

  assign rx_data = r_rx_data;
`else
  logic w_miso_unused;
  assign w_miso_unused = miso;
  assign rx_data       = '0;
`endif

  assign cs_n    = (r_state == IDLE);
  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign bit_sel = r_bit_sel;

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx: two instances (MSB-first CLK_DIV=4, LSB-first CLK_DIV=3).
// Latency: expected per-cycle waveforms computed from transfer phase arithmetic.
// Backpressure: exercises starts while busy, held start (back-to-back) and mid-transfer reset.
module tb_spi_master_tx;

  logic       clk;
  logic       rst_n;
  logic       start   [2];
  logic [7:0] tx_data [2];
  logic       miso    [2];
  logic       sclk    [2];
  logic       mosi    [2];
  logic       cs_n    [2];
  logic [2:0] bit_sel [2];
  logic       busy    [2];
  logic       done    [2];
  logic [7:0] rx_data [2];

  int n_checks = 0;
  int n_errors = 0;

  spi_master_tx #(.CLK_DIV(4), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .tx_data(tx_data[0]), .miso(miso[0]),
    .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs_n[0]), .bit_sel(bit_sel[0]),
    .busy(busy[0]), .done(done[0]), .rx_data(rx_data[0])
  );

  spi_master_tx #(.CLK_DIV(3), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .tx_data(tx_data[1]), .miso(miso[1]),
    .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs_n[1]), .bit_sel(bit_sel[1]),
    .busy(busy[1]), .done(done[1]), .rx_data(rx_data[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  // Bit position carrying the k-th serial bit (k = 0 is the first shifted).
  function automatic int pos_of(input int i, input int k);
    return (i == 0) ? (7 - k) : k;
  endfunction

  function automatic logic [7:0] rx_expect(input logic [7:0] rb);
`ifdef SPI_MASTER_RX_EN
    return rb;
`else
    return (rb & 8'h00);
`endif
  endfunction

  // One transfer on instance i; entered and left at a falling clk edge.
  // Cycle n is the cycle after the n-th rising clk edge following acceptance (edge 0).
  task automatic run_xfer(input int i, input logic [7:0] b, input logic [7:0] rb,
                          input bit hold, input bit glitch);
    int d;
    int h;
    int k;
    logic exp_sclk;
    d = div_of(i);
    start[i]   = 1'b1;
    tx_data[i] = b;
    @(negedge clk);
    if (!hold) start[i] = 1'b0;
    tx_data[i] = ~b;
    for (int n = 1; n <= 18 * d + 1; n++) begin
      exp_sclk = 1'b0;
      if (n <= d) begin
        k = 0;
      end else if (n <= 17 * d) begin
        h = (n - d - 1) / d;
        k = h / 2;
        exp_sclk = h[0];
      end else begin
        k = 7;
      end
      check($sformatf("cs_n[%0d]@%0d", i, n), cs_n[i], (n <= 18 * d) ? 1'b0 : 1'b1);
      check($sformatf("busy[%0d]@%0d", i, n), busy[i], (n <= 18 * d) ? 1'b1 : 1'b0);
      check($sformatf("done[%0d]@%0d", i, n), done[i], (n == 18 * d + 1) ? 1'b1 : 1'b0);
      check($sformatf("sclk[%0d]@%0d", i, n), sclk[i], exp_sclk);
      if (n <= 18 * d) begin
        check($sformatf("bit_sel[%0d]@%0d", i, n), bit_sel[i], pos_of(i, k));
        check($sformatf("mosi[%0d]@%0d", i, n), mosi[i], b[pos_of(i, k)]);
      end else begin
        check($sformatf("rx_data[%0d]", i), rx_data[i], rx_expect(rb));
      end
      miso[i] = rb[pos_of(i, k)];
      if (glitch) begin
        start[i] = (n == 5) || (n == 40);
        if (start[i]) tx_data[i] = 8'($urandom);
      end
      if (n < 18 * d + 1) @(negedge clk);
    end
  endtask

  task automatic idle_check(input int i, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check($sformatf("idle_cs_n[%0d]", i), cs_n[i], 1'b1);
      check($sformatf("idle_done[%0d]", i), done[i], 1'b0);
      check($sformatf("idle_busy[%0d]", i), busy[i], 1'b0);
      check($sformatf("idle_sclk[%0d]", i), sclk[i], 1'b0);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] rb;
    int         i;
    clk   = 1'b0;
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      start[j] = 1'b0; tx_data[j] = 8'h00; miso[j] = 1'b0;
    end
    #12;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rst_cs_n[%0d]", j), cs_n[j], 1'b1);
      check($sformatf("rst_sclk[%0d]", j), sclk[j], 1'b0);
      check($sformatf("rst_busy[%0d]", j), busy[j], 1'b0);
      check($sformatf("rst_done[%0d]", j), done[j], 1'b0);
      check($sformatf("rst_rx[%0d]", j), rx_data[j], 8'h00);
      check($sformatf("rst_bit_sel[%0d]", j), bit_sel[j], (j == 0) ? 3'd7 : 3'd0);
      check($sformatf("rst_mosi[%0d]", j), mosi[j], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: MSB-first 0xA5 with miso 0x3C; LSB-first 0x01.
    run_xfer(0, 8'hA5, 8'h3C, 1'b0, 1'b0);
    idle_check(0, 3);
    run_xfer(1, 8'h01, 8'h3C, 1'b0, 1'b0);
    idle_check(1, 3);

    // Starts while busy, with tx_data changing, must be dropped.
    run_xfer(0, 8'h5E, 8'hC3, 1'b0, 1'b1);
    idle_check(0, 3);
    run_xfer(1, 8'hB2, 8'h4D, 1'b0, 1'b1);
    idle_check(1, 3);

    // Start held through done: back-to-back with one cs_n-high cycle.
    run_xfer(0, 8'h96, 8'h1F, 1'b1, 1'b0);
    run_xfer(0, 8'h69, 8'hE1, 1'b0, 1'b0);
    idle_check(0, 3);

    // Reset dropped at cycle 30 aborts the transfer.
    start[0]   = 1'b1;
    tx_data[0] = 8'h77;
    @(negedge clk);
    start[0] = 1'b0;
    for (int n = 1; n < 30; n++) begin
      miso[0] = 1'($urandom);
      @(negedge clk);
    end
    check("pre_abort_busy", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs_n[0], 1'b1);
    check("abort_sclk", sclk[0], 1'b0);
    check("abort_busy", busy[0], 1'b0);
    check("abort_rx", rx_data[0], 8'h00);
    check("abort_bit_sel", bit_sel[0], 3'd7);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("abort_done", done[0], 1'b0);
    end
    rst_n = 1'b1;
    run_xfer(0, 8'hC7, 8'h5A, 1'b0, 1'b0);
    idle_check(0, 2);

    // Randomized transfers on both instances.
    for (int t = 0; t < 16; t++) begin
      i  = t % 2;
      b  = 8'($urandom);
      rb = 8'($urandom);
      run_xfer(i, b, rb, 1'b0, (t % 3) == 0);
      idle_check(i, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
